// File: rtl/uart_pkg.sv
// Shared UART types and line levels.
// Used by the tx controller and its baud divider.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: tick marks the last cycle of each bit.
// pre warns one cycle ahead that the next cycle is a tick.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic pre
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic ONE = (CLKS_PER_BIT == 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

  // Lets the controller register done in the final cycle.
  assign pre = ONE |
    (run && !tick && ((cnt + 1'b1) == LAST));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, LSB-first data, stop.
// Define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD).
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_o,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = cnt_w(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e            state;
  tx_state_e            state_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_nxt;
  logic                 stop_cnt;
  logic                 stop_nxt;
  logic                 tick;
  logic                 pre;
  logic                 run;
  logic                 lvl;
`ifdef UART_TX_PARITY_EN
  logic                 par;
  logic                 par_nxt;
`else
  logic                 unused_parity;
  assign unused_parity = 1'(PARITY_ODD);
`endif

  assign run = (state != IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .run (run),
    .tick(tick),
    .pre (pre)
  );

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    bit_nxt   = bit_cnt;
    stop_nxt  = stop_cnt;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    unique case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_nxt = START;
          shift_nxt = tx_data;
          bit_nxt   = '0;
          stop_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^tx_data ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
            bit_nxt = '0;
          end else begin
            shift_nxt = shift >> 1;
            bit_nxt   = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            state_nxt = IDLE;
          end else begin
            stop_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        shift_nxt = '0;
        bit_nxt   = '0;
        stop_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    lvl = UART_IDLE_LVL;
    unique case (state_nxt)
      START:   lvl = UART_START_LVL;
      DATA:    lvl = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  lvl = par_nxt;
`endif
      default: lvl = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
      tx_o     <= UART_IDLE_LVL;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_nxt;
      stop_cnt <= stop_nxt;
`ifdef UART_TX_PARITY_EN
      par      <= par_nxt;
`endif
      tx_o     <= lvl;
      tx_ready <= (state_nxt == IDLE);
      busy     <= (state_nxt != IDLE);
      // High during the last stop cycle only.
      done     <= (state_nxt == STOP) &&
                  (stop_nxt == STOP_LAST) && pre;
    end
  end

endmodule
